// File: rtl/video_scan_if.sv
// video_scan_if: control inputs, VRAM read port and colour/sync/status outputs of the scan-out block
interface video_scan_if;
  logic        i_mode;
  logic [7:0]  i_fgbg;
  logic [3:0]  i_brd;
  logic        i_pw;
  logic [3:0]  i_pa;
  logic [11:0] i_pd;
  logic [7:0]  i_vd;
  logic [15:0] o_va;
  logic [3:0]  o_r;
  logic [3:0]  o_g;
  logic [3:0]  o_b;
  logic        o_hs;
  logic        o_vs;
  logic        o_irq;
  logic [7:0]  o_frame;
  modport master (output i_mode, i_fgbg, i_brd, i_pw, i_pa, i_pd, i_vd,
                  input  o_va, o_r, o_g, o_b, o_hs, o_vs, o_irq, o_frame);
  modport slave  (input  i_mode, i_fgbg, i_brd, i_pw, i_pa, i_pd, i_vd,
                  output o_va, o_r, o_g, o_b, o_hs, o_vs, o_irq, o_frame);
endinterface

// File: rtl/video_scan.sv
// video_scan: raster scan-out with pixel-doubled 4bpp/1bpp window, VRAM fetch, palette, vblank IRQ, frame counter
module video_scan #(
  parameter int HZ_BACK  = 48,
  parameter int HZ_VIS   = 640,
  parameter int HZ_FRONT = 16,
  parameter int HZ_SYNC  = 96,
  parameter int VT_BACK  = 33,
  parameter int VT_VIS   = 480,
  parameter int VT_FRONT = 10,
  parameter int VT_SYNC  = 2,
  parameter int BORDER_L = 64
) (
  input logic clk,
  input logic rst,
  video_scan_if.slave bus
);
  localparam logic [15:0] HL  = 16'(HZ_BACK + HZ_VIS + HZ_FRONT + HZ_SYNC - 1);
  localparam logic [15:0] VL  = 16'(VT_BACK + VT_VIS + VT_FRONT + VT_SYNC - 1);
  localparam logic [15:0] HB  = 16'(HZ_BACK);
  localparam logic [15:0] HE  = 16'(HZ_BACK + HZ_VIS);
  localparam logic [15:0] HSE = 16'(HZ_BACK + HZ_VIS + HZ_FRONT);
  localparam logic [15:0] VB  = 16'(VT_BACK);
  localparam logic [15:0] VE  = 16'(VT_BACK + VT_VIS);
  localparam logic [15:0] VSB = 16'(VT_BACK + VT_VIS + VT_FRONT);
  localparam logic [15:0] WL  = 16'(HZ_BACK + BORDER_L);
  localparam logic [15:0] WE  = 16'(HZ_BACK + BORDER_L + 512);
  localparam logic [11:0] PAL_INIT [16] = '{
    12'h111, 12'h008, 12'h080, 12'h088, 12'h800, 12'h808, 12'h880, 12'hCCC,
    12'h888, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
  logic [15:0] r_x, r_y, r_va;
  logic [7:0]  r_vd, r_fgbg, r_frame;
  logic        r_mode, r_irq, r_s1_vis, r_hs1, r_vs1, r_hs, r_vs;
  logic [3:0]  r_s1_idx;
  logic [11:0] r_rgb;
  logic [11:0] r_pal [16];
  logic [15:0] w_p, w_lx, w_ly, w_addr;
  logic [2:0]  w_px, w_bit;
  logic        w_vline, w_vis, w_win, w_fwin;
  logic [3:0]  w_idx;
  assign w_vline = r_y >= VB && r_y < VE;
  assign w_vis   = w_vline && r_x >= HB && r_x < HE;
  assign w_win   = w_vis && r_x >= WL && r_x < WE;
  // Fetch runs three clocks ahead so the byte sits in r_vd when its pixel's position comes up
  assign w_p     = r_x + 16'd3;
  assign w_fwin  = w_vline && w_p >= WL && w_p < WE;
  assign w_ly    = (r_y - VB) >> 1;
  assign w_lx    = (w_p - WL) >> 1;
  assign w_addr  = r_mode ? (w_ly << 5) + (w_lx >> 3) : (w_ly << 7) + (w_lx >> 1);
  assign w_px    = 3'((r_x - WL) >> 1);
  assign w_bit   = 3'd7 - w_px;
  assign w_idx   = !w_win ? bus.i_brd :
                   r_mode ? (r_vd[w_bit] ? r_fgbg[7:4] : r_fgbg[3:0]) :
                   (w_px[0] ? r_vd[3:0] : r_vd[7:4]);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_va     <= '0;
      r_vd     <= '0;
      r_mode   <= 1'b0;
      r_fgbg   <= '0;
      r_frame  <= '0;
      r_irq    <= 1'b0;
      r_s1_vis <= 1'b0;
      r_s1_idx <= '0;
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b0;
      r_rgb    <= '0;
      r_pal    <= PAL_INIT;
    end else begin
      r_x <= r_x == HL ? 16'd0 : r_x + 16'd1;
      if (r_x == HL) r_y <= r_y == VL ? 16'd0 : r_y + 16'd1;
      if (r_x == 16'd0 && r_y == 16'd0) begin
        r_mode  <= bus.i_mode;
        r_fgbg  <= bus.i_fgbg;
        r_frame <= r_frame + 8'd1;
      end
      r_irq    <= r_x == 16'd0 && r_y == VE;
      if (w_fwin) r_va <= w_addr;
      r_vd     <= bus.i_vd;
      r_s1_vis <= w_vis;
      r_s1_idx <= w_idx;
      r_hs1    <= r_x < HSE;
      r_vs1    <= r_y >= VSB;
      r_hs     <= r_hs1;
      r_vs     <= r_vs1;
      r_rgb    <= r_s1_vis ? r_pal[r_s1_idx] : 12'h000;
      if (bus.i_pw) r_pal[bus.i_pa] <= bus.i_pd;
    end
  end
  assign bus.o_va    = r_va;
  assign bus.o_r     = r_rgb[11:8];
  assign bus.o_g     = r_rgb[7:4];
  assign bus.o_b     = r_rgb[3:0];
  assign bus.o_hs    = r_hs;
  assign bus.o_vs    = r_vs;
  assign bus.o_irq   = r_irq;
  assign bus.o_frame = r_frame;
endmodule

// File: tb/tb_video_scan.sv
// tb_video_scan: randomized scoreboard bench for video_scan against a frame-level behavioural model
module tb_video_scan;
  localparam int HB = 4, HV = 520, HF = 4, HSY = 8, VB = 2, VV = 6, VF = 1, VSY = 2, BL = 4;
  localparam int HT = HB + HV + HF + HSY, VT = VB + VV + VF + VSY, WL = HB + BL;
  localparam logic [11:0] DEF_PAL [16] = '{
    12'h111, 12'h008, 12'h080, 12'h088, 12'h800, 12'h808, 12'h880, 12'hCCC,
    12'h888, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
  typedef struct {longint due; logic [13:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  video_scan_if bus();
  video_scan #(.HZ_BACK(HB), .HZ_VIS(HV), .HZ_FRONT(HF), .HZ_SYNC(HSY), .VT_BACK(VB),
               .VT_VIS(VV), .VT_FRONT(VF), .VT_SYNC(VSY), .BORDER_L(BL))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] vram [65536];
  always @(posedge clk) bus.i_vd <= vram[bus.o_va];
  exp_t px_q[$], ctl_q[$];
  int va_q[$];
  longint cyc = 0;
  int mt = 0, m_last_va = 0, rst_seq = 0, seen_rst = 0, last_va = 0, n_cmp = 0, n_bad = 0;
  logic m_mode = 1'b0;
  logic [7:0] m_fgbg = '0, m_frame = '0;
  logic [11:0] m_pal [16];
  function automatic logic [11:0] colour(int x, int y);
    int lx, ly;
    logic [7:0] d;
    logic [3:0] idx;
    if (x < HB || x >= HB + HV || y < VB || y >= VB + VV) return 12'h000;
    if (x < WL || x >= WL + 512) return m_pal[bus.i_brd];
    lx = (x - WL) / 2;
    ly = (y - VB) / 2;
    d = m_mode ? vram[ly * 32 + lx / 8] : vram[ly * 128 + lx / 2];
    if (m_mode) idx = d[7 - lx % 8] ? m_fgbg[7:4] : m_fgbg[3:0];
    else idx = (lx % 2 == 1) ? d[3:0] : d[7:4];
    return m_pal[idx];
  endfunction
  // Model: position from cycles since reset, expectations tagged with the cycle they must appear
  always @(posedge clk) begin
    int x, y, w, a;
    if (rst) begin
      while (px_q.size() > 0 && px_q[$].due > cyc) void'(px_q.pop_back());
      while (ctl_q.size() > 0 && ctl_q[$].due > cyc) void'(ctl_q.pop_back());
      px_q.push_back('{cyc + 1, 14'b10});
      px_q.push_back('{cyc + 2, 14'b10});
      ctl_q.push_back('{cyc + 1, 14'h0});
      va_q.delete();
      m_last_va = 0;
      rst_seq++;
      mt = 0;
      m_mode = 1'b0;
      m_fgbg = '0;
      m_frame = '0;
      m_pal = DEF_PAL;
    end else begin
      x = mt % HT;
      y = (mt / HT) % VT;
      if (bus.i_pw) m_pal[bus.i_pa] = bus.i_pd;
      px_q.push_back('{cyc + 2, {colour(x, y), 1'(x < HB + HV + HF), 1'(y >= VB + VV + VF)}});
      if (x == 0 && y == 0) begin
        m_mode = bus.i_mode;
        m_fgbg = bus.i_fgbg;
        m_frame = m_frame + 8'd1;
      end
      ctl_q.push_back('{cyc + 2 - 1, {5'd0, 1'(x == 0 && y == VB + VV), m_frame}});
      if (x == 0 && y >= VB && y < VB + VV) begin
        w = m_mode ? 32 : 128;
        for (int i = 0; i < w; i++) begin
          a = ((y - VB) / 2) * w + i;
          if (a != m_last_va) va_q.push_back(a);
          m_last_va = a;
        end
      end
      mt++;
    end
    cyc++;
  end
  always @(negedge clk) begin
    exp_t e;
    int ev;
    logic [13:0] act;
    if (seen_rst != rst_seq) begin
      seen_rst = rst_seq;
      last_va = int'(bus.o_va);
    end else if (int'(bus.o_va) != last_va) begin
      last_va = int'(bus.o_va);
      n_cmp++;
      if (va_q.size() == 0) begin
        n_bad++;
        $display("FAIL va_order cyc=%0d: got VA=%0d, required no new address", cyc, last_va);
      end else begin
        ev = va_q.pop_front();
        if (ev != last_va) begin
          n_bad++;
          $display("FAIL va_order cyc=%0d: got VA=%0d, required %0d", cyc, last_va, ev);
        end
      end
    end
    if (px_q.size() > 0 && px_q[0].due == cyc) begin
      e = px_q.pop_front();
      act = {bus.o_r, bus.o_g, bus.o_b, bus.o_hs, bus.o_vs};
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL pixel cyc=%0d: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
                 cyc, act[13:2], act[1], act[0], e.v[13:2], e.v[1], e.v[0]);
      end
    end
    if (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
      e = ctl_q.pop_front();
      act = {5'd0, bus.o_irq, bus.o_frame};
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL irq_frame cyc=%0d: got irq=%b frame=%0d, required irq=%b frame=%0d",
                 cyc, act[8], act[7:0], e.v[8], e.v[7:0]);
      end
    end
  end
  task automatic run(int n, bit rnd);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.i_pw = 1'b0;
      if (rnd) begin
        bus.i_brd = 4'($urandom);
        bus.i_pw  = ($urandom % 12) == 0;
        bus.i_pa  = 4'($urandom);
        bus.i_pd  = 12'($urandom);
        if ($urandom % 700 == 0) bus.i_mode = ~bus.i_mode;
        if ($urandom % 900 == 0) bus.i_fgbg = 8'($urandom);
      end
    end
  endtask
  initial begin
    bus.i_mode = 1'b0;
    bus.i_fgbg = 8'h00;
    bus.i_brd  = 4'd1;
    bus.i_pw   = 1'b0;
    bus.i_pa   = 4'd0;
    bus.i_pd   = 12'h000;
    for (int i = 0; i < 65536; i++) vram[i] = 8'h7C;
    run(3, 1'b0);
    rst = 1'b0;
    run(HT * VT + 50, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 65536; i++) vram[i] = 8'h00;
    vram[0] = 8'h81;
    bus.i_mode = 1'b1;
    bus.i_fgbg = 8'hE1;
    run(2, 1'b0);
    rst = 1'b0;
    run(HT * VT + 50, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    bus.i_mode = 1'b0;
    run(2, 1'b0);
    rst = 1'b0;
    run(HT * VT * 3 / 2, 1'b1);
    rst = 1'b1;
    run(1, 1'b1);
    rst = 1'b0;
    run(HT * VT * 2 + 100, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
